dpram_stream_reader: RTL and testbench

DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

---
 rtl/dpram_stream_reader.sv | 144 ++++++++++++++
 tb/tb_dpram_stream_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Streams a contiguous block of words out of a dual-port RAM read port.
// Reads are credit-limited against a 2-entry output FIFO so RAM data is never lost under backpressure.
module dpram_stream_reader #(
  parameter int unsigned data_width_g = 8,
  parameter int unsigned addr_width_g = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [addr_width_g-1:0] start_addr,
  input  logic [addr_width_g-1:0] length,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_cs,
  output logic                    mem_wren,
  output logic [addr_width_g-1:0] mem_address,
  input  logic [data_width_g-1:0] mem_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [data_width_g-1:0] out_data,
  output logic                    out_last
);

  localparam logic [addr_width_g-1:0] ONE = addr_width_g'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [addr_width_g-1:0] addr_q, addr_d;
  logic [addr_width_g-1:0] issue_cnt_q, issue_cnt_d;
  logic [addr_width_g-1:0] out_cnt_q, out_cnt_d;
  logic                    inflight_q, inflight_d;
  logic                    done_q, done_d;
  logic [data_width_g-1:0] fifo_q [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    push;
  logic                    pop;
  logic                    issue;
  logic [2:0]              occ;

  // State register; reset also drops any read still in flight so its data is never pushed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_q;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d     = count_q + 2'(push) - 2'(pop);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = READ;
            addr_d      = start_addr;
            issue_cnt_d = length;
            out_cnt_d   = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue && (issue_cnt_q == ONE)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (out_cnt_q == ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      addr_d      = addr_q + ONE;
      issue_cnt_d = issue_cnt_q - ONE;
    end
    if (pop) begin
      out_cnt_d = out_cnt_q - ONE;
    end
  end

  // Outputs. The issue credit counts buffered words plus the read whose data is on mem_q now,
  // less this cycle's pop, so a read issued here always has a free slot when it lands.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    mem_wren    = 1'b0;
    mem_address = addr_q;
    out_valid   = (count_q != 2'd0);
    out_data    = out_valid ? fifo_q[rd_ptr_q] : '0;
    out_last    = out_valid && (out_cnt_q == ONE);
    pop         = out_valid && out_ready;
    push        = inflight_q;
    occ         = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue       = (state_q == READ) && (issue_cnt_q != '0) && (occ < 3'd2);
    mem_cs      = issue;
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: table of directed transfers, abort/restart sequence,
// then random transfers under random backpressure against a queue-based reference.
module tb_dpram_stream_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] start_addr = '0;
  logic [13:0] length = '0;
  logic        busy, done, mem_cs, mem_wren;
  logic [13:0] mem_address;
  logic [7:0]  mem_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;

  logic [7:0]  ram [16384];

  int checks = 0;
  int failures = 0;

  localparam int DC = -99;

  dpram_stream_reader #(
    .data_width_g(8),
    .addr_width_g(14)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .mem_cs     (mem_cs),
    .mem_wren   (mem_wren),
    .mem_address(mem_address),
    .mem_q      (mem_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clock = ~clock;

  // RAM read port with one-cycle registered read.
  always @(posedge clock) begin
    if (mem_cs) mem_q <= ram[mem_address];
  end

  typedef struct {
    logic [13:0] sa;
    logic [13:0] len;
    int          mode;
    bit          repulse;
    int          exp_beats;
    int          exp_first_c;
    int          exp_done_c;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       return 1'($urandom_range(0, 1));
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Runs one transfer. Called at a negedge with start low; cycle 0 is the cycle after the accepting edge.
  task automatic do_xfer(input logic [13:0] sa, input logic [13:0] len, input int mode,
                         input bit repulse, input int abort_after,
                         output int nbeats, output int first_c, output int done_c,
                         output int ndone, output logic [7:0] first_d, output logic [7:0] last_d);
    logic [7:0]  expq[$];
    logic [13:0] exp_addr;
    logic [7:0]  beat;
    logic [7:0]  hold_d;
    int          issued, last_c, end_c;
    bit          hold_v, hold_l, stop, fin;
    expq = {};
    for (int k = 0; k < int'(len); k++) expq.push_back(ram[14'(int'(sa) + k)]);
    exp_addr = sa; issued = 0; nbeats = 0; first_c = -1; done_c = -1; ndone = 0; last_c = -1;
    hold_v = 1'b0; hold_l = 1'b0; hold_d = '0; first_d = '0; last_d = '0; stop = 1'b0; fin = 1'b0;
    start = 1'b1; start_addr = sa; length = len; out_ready = 1'b1;
    @(negedge clock);
    for (int cyc = 0; cyc < 400 && !stop; cyc++) begin
      start = repulse && (cyc == 3);
      if (start) begin
        start_addr = 14'h2000;
        length     = 14'd9;
      end
      out_ready = ready_pat(mode, cyc);
      #1;
      check("busy", busy, (len != 0) && (last_c < 0));
      check("done", done, (len == 0) ? (cyc == 0) : (last_c >= 0 && cyc == last_c + 1));
      if (mem_cs) begin
        check("rd_addr", mem_address, exp_addr);
        check("wren", mem_wren, 0);
        exp_addr++;
        issued++;
      end
      if (hold_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_d);
        check("stall_last", out_last, hold_l);
      end
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = cyc;
      end
      if (out_valid && first_c < 0) first_c = cyc;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_beat", nbeats + 1, int'(len));
        end else begin
          beat = expq.pop_front();
          check("beat_data", out_data, beat);
          check("beat_last", out_last, expq.size() == 0);
          if (nbeats == 0) first_d = out_data;
          last_d = out_data;
          nbeats++;
          if (expq.size() == 0) last_c = cyc;
        end
      end
      check("credit", (issued - nbeats) <= 2, 1);
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      end_c = (len == 0) ? 3 : ((last_c >= 0) ? last_c + 4 : 100000);
      if (abort_after > 0 && nbeats == abort_after) begin
        stop = 1'b1;
      end else if (cyc >= end_c) begin
        stop = 1'b1;
        fin  = 1'b1;
      end
      if (!stop) @(negedge clock);
    end
    start = 1'b0;
    if (!stop) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d beats expected %0d", nbeats, len);
    end else if (fin) begin
      check("beats_total", nbeats, int'(len));
      check("issued_total", issued, int'(len));
      check("done_count", ndone, 1);
    end
  endtask

  initial begin
    int nb, fc, dc, nd;
    logic [7:0] fd, ld;
    logic [13:0] rsa, rlen;

    for (int i = 0; i < 16384; i++) ram[i] = 8'(i);

    vecs[0] = '{14'h0010, 14'd4, 0, 1'b0, 4, 2, 6,  8'h10, 8'h13};
    vecs[1] = '{14'h3FFE, 14'd4, 0, 1'b0, 4, 2, 6,  8'hFE, 8'h01};
    vecs[2] = '{14'h0020, 14'd8, 1, 1'b0, 8, 2, DC, 8'h20, 8'h27};
    vecs[3] = '{14'h0100, 14'd0, 0, 1'b0, 0, -1, 0, 8'h00, 8'h00};
    vecs[4] = '{14'h1234, 14'd1, 0, 1'b0, 1, 2, 3,  8'h34, 8'h34};
    vecs[5] = '{14'h0040, 14'd6, 0, 1'b1, 6, 2, 8,  8'h40, 8'h45};
    vecs[6] = '{14'h3FFF, 14'd3, 0, 1'b0, 3, 2, 5,  8'hFF, 8'h01};
    vecs[7] = '{14'h0000, 14'd2, 1, 1'b0, 2, 2, DC, 8'h00, 8'h01};

    // Reset state
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_address, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      do_xfer(vecs[i].sa, vecs[i].len, vecs[i].mode, vecs[i].repulse, 0, nb, fc, dc, nd, fd, ld);
      check($sformatf("v%0d_beats", i), nb, vecs[i].exp_beats);
      check($sformatf("v%0d_first_valid_cyc", i), fc, vecs[i].exp_first_c);
      if (vecs[i].exp_done_c != DC) check($sformatf("v%0d_done_cyc", i), dc, vecs[i].exp_done_c);
      if (vecs[i].exp_beats > 0) begin
        check($sformatf("v%0d_first_data", i), fd, vecs[i].exp_first);
        check($sformatf("v%0d_last_data", i), ld, vecs[i].exp_last);
      end
    end

    // Abort after 5 beats of a 16-word transfer, then a clean restart.
    do_xfer(14'h0200, 14'd16, 0, 1'b0, 5, nb, fc, dc, nd, fd, ld);
    check("abort_beats", nb, 5);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_mem_cs", mem_cs, 0);
    check("abort_wren", mem_wren, 0);
    check("abort_addr", mem_address, 0);
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_last", out_last, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      #1;
      check("post_abort_valid", out_valid, 0);
      check("post_abort_done", done, 0);
      check("post_abort_mem_cs", mem_cs, 0);
    end
    do_xfer(14'h0300, 14'd2, 0, 1'b0, 0, nb, fc, dc, nd, fd, ld);
    check("restart_beats", nb, 2);
    check("restart_done_cyc", dc, 4);
    check("restart_first", fd, 8'h00);
    check("restart_last", ld, 8'h01);

    // Random contents, addresses, lengths and backpressure.
    for (int i = 0; i < 16384; i++) ram[i] = 8'($urandom);
    for (int t = 0; t < 24; t++) begin
      rsa  = 14'($urandom);
      if (t < 4) rsa = 14'h3FF0 + 14'($urandom_range(0, 15));
      rlen = 14'($urandom_range(0, 24));
      do_xfer(rsa, rlen, $urandom_range(2, 3), (rlen >= 4) && ($urandom_range(0, 1) == 1), 0,
              nb, fc, dc, nd, fd, ld);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
